// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes, FSM states, access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // Undefined funct3 codes fall through to a full-word access.
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = SZ_BYTE;
            F3_H, F3_HU: size_of = SZ_HALF;
            default:     size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed(input logic [2:0] f3);
        is_signed = (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data aligner: picks the addressed byte/half out of the bus word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        // Lanes beyond the top of the word shift in zeros (half at off=3 keeps lane 3 only).
        shifted = rdata >> {off, 3'b000};
        case (size_of(func3))
            SZ_BYTE: load_data = is_signed(func3) ? {{24{shifted[7]}}, shifted[7:0]}
                                                  : {24'b0, shifted[7:0]};
            SZ_HALF: load_data = is_signed(func3) ? {{16{shifted[15]}}, shifted[15:0]}
                                                  : {16'b0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data bus master with byte strobes, pipeline stall and timeout.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              lsu_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              lsu_done,
    output logic              lsu_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              bus_req_q, bus_we_q, err_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        wstrb_q, wstrb_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [31:0]       load_data_q, load_aligned;
    logic [2:0]        f3_q;
    logic [1:0]        off_q, off;
    logic [CNT_W-1:0]  cnt_q;
    logic              op, misalign, timeout_hit;
    lsu_size_e         size;

    assign op          = mem_read | mem_write;
    assign off         = addr[1:0];
    assign size        = size_of(func3);
    assign timeout_hit = (state_q == S_REQ) && (cnt_q == CNT_LAST) && !bus_ack;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Store lanes; loads always read the full word.
    always_comb begin
        wstrb_nxt = STRB_WORD;
        wdata_nxt = wdata[31:0];
        case (size)
            SZ_BYTE: begin
                wstrb_nxt = STRB_BYTE << off;
                wdata_nxt = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                wstrb_nxt = STRB_HALF << off;
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                wstrb_nxt = STRB_WORD;
                wdata_nxt = wdata[31:0];
            end
        endcase
        if (mem_read) begin
            wstrb_nxt = STRB_WORD;
            wdata_nxt = '0;
        end
    end

    lsu_load_align u_align (
        .rdata     (bus_rdata[31:0]),
        .off       (off_q),
        .func3     (f3_q),
        .load_data (load_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (op) state_d = misalign ? S_DONE : S_REQ;
            S_REQ:  if (bus_ack || timeout_hit) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_stall = 1'b0;
        lsu_done  = 1'b0;
        case (state_q)
            S_IDLE: lsu_stall = op;
            S_REQ:  lsu_stall = 1'b1;
            S_DONE: lsu_done  = 1'b1;
            default: begin
                lsu_stall = 1'b0;
                lsu_done  = 1'b0;
            end
        endcase
        // Timeout error fires in the last REQ cycle; the misalign error is registered into DONE.
        lsu_err = err_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op && misalign) begin
                        err_q       <= 1'b1;
                        load_data_q <= '0;
                    end else if (op) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= ~mem_read;
                        bus_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                        wstrb_q    <= wstrb_nxt;
                        wdata_q    <= wdata_nxt;
                        f3_q       <= func3;
                        off_q      <= off;
                        cnt_q      <= '0;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        if (!bus_we_q) load_data_q <= load_aligned;
                    end else if (timeout_hit) begin
                        bus_req_q   <= 1'b0;
                        load_data_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = DATA_W'(wdata_q);
    assign load_data = DATA_W'(load_data_q);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops push expected bus/completion records,
// negedge monitors pop and compare them.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] load_data;

    mem_stage_lsu #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .func3     (func3),
        .addr      (addr),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .lsu_stall (lsu_stall),
        .load_data (load_data),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        chk_wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] load;
        logic        chk_ld;
        logic        err;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    bus_exp_t  mon_b;
    done_exp_t mon_d;
    logic      err_pending = 1'b0;
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Bus monitor: one expected record per acknowledged transfer.
    always @(negedge clk) begin
        if (!rst && bus_req && bus_ack) begin
            if (bus_q.size() == 0) begin
                fail("bus_unexpected");
            end else begin
                mon_b = bus_q.pop_front();
                check("bus_addr", bus_addr, mon_b.addr);
                check("bus_we", {31'b0, bus_we}, {31'b0, mon_b.we});
                check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, mon_b.strb});
                if (mon_b.chk_wd) check("bus_wdata", bus_wdata, mon_b.wdata);
            end
        end
    end

    // Completion monitor: error may arrive with lsu_done or in the cycle before it.
    always @(negedge clk) begin
        if (rst) begin
            err_pending = 1'b0;
        end else if (lsu_done) begin
            if (done_q.size() == 0) begin
                fail("done_unexpected");
            end else begin
                mon_d = done_q.pop_front();
                check("done_err", {31'b0, lsu_err | err_pending}, {31'b0, mon_d.err});
                if (mon_d.chk_ld) check("load_data", load_data, mon_d.load);
            end
            err_pending = 1'b0;
        end else if (lsu_err) begin
            err_pending = 1'b1;
        end
    end

    // ack_after: REQ cycle index in which ack is given; negative means never (timeout).
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                         input int ack_after, input logic [31:0] exp_addr,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_load, input logic chk_ld);
        bus_exp_t  b;
        done_exp_t d;
        int        cyc;
        b.addr   = exp_addr;
        b.we     = wr & ~rd;
        b.strb   = exp_strb;
        b.wdata  = exp_wdata;
        b.chk_wd = ~rd;
        d.load   = exp_load;
        d.chk_ld = chk_ld;
        d.err    = (ack_after < 0);
        if (ack_after >= 0) bus_q.push_back(b);
        done_q.push_back(d);
        mem_read  = rd;
        mem_write = wr;
        func3     = f3;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        check("stall_c0", {31'b0, lsu_stall}, 32'd1);
        check("req_c0", {31'b0, bus_req}, 32'd0);
        @(posedge clk);
        #1;
        cyc = 0;
        forever begin
            if (cyc == ack_after) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            @(negedge clk);
            check("req_hold", {31'b0, bus_req}, 32'd1);
            check("stall_req", {31'b0, lsu_stall}, 32'd1);
            check("err_req", {31'b0, lsu_err}, (ack_after < 0 && cyc == TO - 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = '0;
            cyc++;
            if (ack_after >= 0 && cyc == ack_after + 1) break;
            if (ack_after < 0 && cyc == TO) break;
            if (cyc >= 4 * TO) begin
                fail("req_budget");
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("done_pulse", {31'b0, lsu_done}, 32'd1);
        check("stall_done", {31'b0, lsu_stall}, 32'd0);
        check("req_done", {31'b0, bus_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        func3     = '0;
        addr      = '0;
        wdata     = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_done", {31'b0, lsu_done}, 32'd0);
        check("rst_err", {31'b0, lsu_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // rd wr f3 addr wdata rdata ack_after exp_addr strb exp_wdata exp_load chk_ld
        do_op(1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,
              32'hDEADBEEF, 1);
        do_op(1, 0, F3_B,  32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'b1111, 32'h0,
              32'hFFFFFF80, 1);
        do_op(1, 0, F3_BU, 32'h103, 32'h0,        32'h80FF0000, 1, 32'h100, 4'b1111, 32'h0,
              32'h00000080, 1);
        do_op(0, 1, F3_H,  32'h202, 32'h0000ABCD, 32'h0,        0, 32'h200, 4'b1100, 32'hABCDABCD,
              32'h0, 0);
        do_op(1, 0, F3_H,  32'h102, 32'h0,        32'h80011234, 0, 32'h100, 4'b1111, 32'h0,
              32'hFFFF8001, 1);
        do_op(1, 0, F3_HU, 32'h102, 32'h0,        32'h80011234, 2, 32'h100, 4'b1111, 32'h0,
              32'h00008001, 1);
        do_op(0, 1, F3_B,  32'h301, 32'h123456A5, 32'h0,        0, 32'h300, 4'b0010, 32'hA5A5A5A5,
              32'h0, 0);
        do_op(0, 1, F3_W,  32'h404, 32'hCAFEF00D, 32'h0,        2, 32'h404, 4'b1111, 32'hCAFEF00D,
              32'h0, 0);
        do_op(1, 0, 3'b110, 32'h500, 32'h0,       32'h12345678, 0, 32'h500, 4'b1111, 32'h0,
              32'h12345678, 1);
        do_op(1, 1, F3_W,  32'h800, 32'hFFFFFFFF, 32'h0BADF00D, 0, 32'h800, 4'b1111, 32'h0,
              32'h0BADF00D, 1);
        // No ack: bus_req for TO cycles, error, load_data cleared.
        do_op(1, 0, F3_W,  32'h600, 32'h0,        32'h0,       -1, 32'h600, 4'b1111, 32'h0,
              32'h0, 1);
        do_op(1, 0, F3_W,  32'h604, 32'h0,        32'h55AA55AA, 3, 32'h604, 4'b1111, 32'h0,
              32'h55AA55AA, 1);

`ifdef LSU_MISALIGN_TRAP_EN
        begin
            done_exp_t d;
            d.load   = 32'h0;
            d.chk_ld = 1'b1;
            d.err    = 1'b1;
            done_q.push_back(d);
            mem_read = 1'b1;
            func3    = F3_W;
            addr     = 32'h101;
            @(negedge clk);
            check("mis_stall_c0", {31'b0, lsu_stall}, 32'd1);
            check("mis_req_c0", {31'b0, bus_req}, 32'd0);
            @(posedge clk);
            #1;
            mem_read = 1'b0;
            @(negedge clk);
            check("mis_req_c1", {31'b0, bus_req}, 32'd0);
            check("mis_err_c1", {31'b0, lsu_err}, 32'd1);
            check("mis_done_c1", {31'b0, lsu_done}, 32'd1);
            @(posedge clk);
            #1;
        end
`else
        // Half at off=3 keeps lane 3 only.
        do_op(0, 1, F3_H,  32'h203, 32'h00001234, 32'h0,        0, 32'h200, 4'b1000, 32'h12341234,
              32'h0, 0);
`endif

        // Reset in the middle of REQ, then a stray ack.
        mem_read = 1'b1;
        func3    = F3_W;
        addr     = 32'h700;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("rr_req", {31'b0, bus_req}, 32'd0);
        check("rr_we", {31'b0, bus_we}, 32'd0);
        check("rr_strb", {28'b0, bus_wstrb}, 32'd0);
        check("rr_addr", bus_addr, 32'd0);
        check("rr_wdata", bus_wdata, 32'd0);
        check("rr_load", load_data, 32'd0);
        check("rr_stall", {31'b0, lsu_stall}, 32'd0);
        check("rr_done", {31'b0, lsu_done}, 32'd0);
        check("rr_err", {31'b0, lsu_err}, 32'd0);
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        check("rr_done2", {31'b0, lsu_done}, 32'd0);
        check("rr_req2", {31'b0, bus_req}, 32'd0);
        check("rr_load2", load_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        check("bus_q_empty", bus_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
